pixel_word_packer: RTL and testbench

- Camera-side stage that sits directly upstream of the DDR3 traffic generator's camera write streams.
- Takes the per-pixel camera stream and packs consecutive pixels into 128-bit words, one word per DRAM address.
- Drives the write AXI-Stream with TLAST on the final word of each frame, so the downstream write address counter realigns every frame.
- The camera cannot be back-pressured, so overflow is detected, flagged and recovered from cleanly.

---
 rtl/pixel_word_packer_if.sv | 22 ++
 rtl/pixel_word_packer.sv | 181 ++++++++++++++++++
 tb/tb_pixel_word_packer.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_word_packer_if.sv
// Write-side AXI-Stream bundle between pixel_word_packer and the DRAM write stream.
// The master drives the 128-bit word, valid and tlast; the slave returns ready.
interface pixel_word_packer_if;
  logic [127:0] m_axis_data;
  logic         m_axis_valid;
  logic         m_axis_tlast;
  logic         m_axis_ready;

  modport master (
    output m_axis_data,
    output m_axis_valid,
    output m_axis_tlast,
    input  m_axis_ready
  );

  modport slave (
    input  m_axis_data,
    input  m_axis_valid,
    input  m_axis_tlast,
    output m_axis_ready
  );
endinterface

// File: rtl/pixel_word_packer.sv
// Packs camera pixels into 128-bit words, with frame TLAST and overflow/SOF-error recovery.
// Define PIXEL_WORD_PACKER_STATS_EN to add the frames_out/drops_out counters.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a valid SOF pixel
// ST_PACK  | collecting pixels of the current frame into words
// ST_FLUSH | frame lost; waiting for buffer space to push a zero TLAST word
module pixel_word_packer #(
  parameter int PIXEL_WIDTH = 16,
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   pixel_valid_in,
  input  logic [PIXEL_WIDTH-1:0] pixel_data_in,
  input  logic                   pixel_sof_in,
  pixel_word_packer_if.master    m_axis,
  output logic                   overflow_out,
  output logic                   frame_err_out,
  input  logic                   clr_err_in
`ifdef PIXEL_WORD_PACKER_STATS_EN
  ,
  output logic [15:0]            frames_out,
  output logic [15:0]            drops_out
`endif
);

  localparam int PPW   = 128 / PIXEL_WIDTH;
  localparam int WORDS = (H_ACTIVE * V_ACTIVE) / PPW;
  localparam int LW    = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  if (PIXEL_WIDTH != 8 && PIXEL_WIDTH != 16 && PIXEL_WIDTH != 32) begin : g_bad_width
    $error("pixel_word_packer: PIXEL_WIDTH must be 8, 16 or 32");
  end
  if (((H_ACTIVE * V_ACTIVE) % PPW) != 0) begin : g_bad_geom
    $error("pixel_word_packer: H_ACTIVE*V_ACTIVE must be a multiple of pixels per word");
  end

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PACK  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [LW-1:0] lane, lane_nxt, cur_lane;
  logic [CW-1:0] word_cnt, cnt_nxt, cur_cnt;
  logic [127:0]  acc, word_next;

  logic [127:0]  fifo_d [2];
  logic          fifo_l [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    count;

  logic space, pop, start, take, sof_err, word_done, last_word;
  logic push_real, push_term, push, ovf_set, push_last, m_valid;
  logic [127:0] push_data;

  assign m_valid             = (count != 2'd0);
  assign m_axis.m_axis_valid = m_valid;
  assign m_axis.m_axis_data  = fifo_d[rd_ptr];
  assign m_axis.m_axis_tlast = fifo_l[rd_ptr];

  // Space is taken from the registered count only, so ready never reaches the push path.
  always_comb begin
    cur_lane  = (state == ST_IDLE) ? '0 : lane;
    cur_cnt   = (state == ST_IDLE) ? '0 : word_cnt;
    space     = (count < 2'd2);
    pop       = m_valid && m_axis.m_axis_ready;
    start     = (state == ST_IDLE) && pixel_valid_in && pixel_sof_in;
    take      = start || ((state == ST_PACK) && pixel_valid_in && !pixel_sof_in);
    sof_err   = (state == ST_PACK) && pixel_valid_in && pixel_sof_in;
    word_done = take && (cur_lane == LW'(PPW - 1));
    last_word = (cur_cnt == CW'(WORDS - 1));
    word_next = acc;
    for (int k = 0; k < PPW; k++) begin
      if (cur_lane == LW'(k)) word_next[k*PIXEL_WIDTH +: PIXEL_WIDTH] = pixel_data_in;
    end
    push_real = word_done && space;
    ovf_set   = word_done && !space;
    push_term = (state == ST_FLUSH) && space;
    push      = push_real || push_term;
    push_data = push_term ? '0 : word_next;
    push_last = push_term || last_word;
  end

  always_comb begin
    state_nxt = state;
    lane_nxt  = lane;
    cnt_nxt   = word_cnt;
    if (take) begin
      if (word_done) begin
        lane_nxt = '0;
        cnt_nxt  = cur_cnt;
        if (!space) begin
          state_nxt = ST_FLUSH;
        end else if (last_word) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          state_nxt = ST_PACK;
          cnt_nxt   = cur_cnt + CW'(1);
        end
      end else begin
        state_nxt = ST_PACK;
        lane_nxt  = cur_lane + LW'(1);
        cnt_nxt   = cur_cnt;
      end
    end else if (sof_err) begin
      state_nxt = ST_FLUSH;
      lane_nxt  = '0;
    end else if (push_term) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= ST_IDLE;
      lane     <= '0;
      word_cnt <= '0;
      acc      <= '0;
    end else begin
      state    <= state_nxt;
      lane     <= lane_nxt;
      word_cnt <= cnt_nxt;
      if (take) acc <= word_next;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fifo_d[0] <= '0;
      fifo_d[1] <= '0;
      fifo_l[0] <= 1'b0;
      fifo_l[1] <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr] <= push_data;
        fifo_l[wr_ptr] <= push_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // A set event in the same cycle as clr_err_in keeps the flag set.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      overflow_out  <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      if (ovf_set)         overflow_out <= 1'b1;
      else if (clr_err_in) overflow_out <= 1'b0;
      if (sof_err)         frame_err_out <= 1'b1;
      else if (clr_err_in) frame_err_out <= 1'b0;
    end
  end

`ifdef PIXEL_WORD_PACKER_STATS_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      frames_out <= '0;
      drops_out  <= '0;
    end else begin
      if (push_real && last_word) frames_out <= frames_out + 16'd1;
      if (ovf_set || sof_err)     drops_out  <= drops_out + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_word_packer.sv
// Bench for pixel_word_packer (16x2 frame, 16-bit pixels): directed table, corner sequences
// and random traffic, all compared against a queue-based frame/word reference model.
module tb_pixel_word_packer;
  localparam int PW    = 16;
  localparam int PPW   = 8;
  localparam int WORDS = 4;
  localparam logic [127:0] W0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
  localparam logic [127:0] W1 = 128'h000f_000e_000d_000c_000b_000a_0009_0008;
  localparam logic [127:0] W3 = 128'h001f_001e_001d_001c_001b_001a_0019_0018;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          pixel_valid_in;
  logic [PW-1:0] pixel_data_in;
  logic          pixel_sof_in;
  logic          overflow_out;
  logic          frame_err_out;
  logic          clr_err_in;
`ifdef PIXEL_WORD_PACKER_STATS_EN
  logic [15:0]   frames_out;
  logic [15:0]   drops_out;
`endif

  pixel_word_packer_if bus ();

  pixel_word_packer #(.PIXEL_WIDTH(PW), .H_ACTIVE(16), .V_ACTIVE(2)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .pixel_valid_in (pixel_valid_in),
    .pixel_data_in  (pixel_data_in),
    .pixel_sof_in   (pixel_sof_in),
    .m_axis         (bus),
    .overflow_out   (overflow_out),
    .frame_err_out  (frame_err_out),
    .clr_err_in     (clr_err_in)
`ifdef PIXEL_WORD_PACKER_STATS_EN
    ,
    .frames_out     (frames_out),
    .drops_out      (drops_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [127:0] d;
    logic         l;
  } wrd_t;

  typedef struct {
    int           pre;
    int           err_pix;
    int           rmode;
    int           nwords;
    logic [127:0] w_first;
    logic [127:0] w_last;
    logic         ovf;
    logic         ferr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model state
  wrd_t          mq[$];
  logic [PW-1:0] pix_q[$];
  int            m_mode;   // 0 waiting for SOF, 1 in frame, 2 frame lost
  int            m_wcnt;
  logic          m_ovf, m_ferr;

  // words accepted from the DUT in the current scenario
  logic [127:0]  rx_d [16];
  logic          rx_l [16];
  int            rx_cnt, rx_tl_cnt;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pix_q.delete();
    m_mode = 0;
    m_wcnt = 0;
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic model_update();
    logic space, pop, set_o, set_f, pushit;
    wrd_t w;
    space  = (mq.size() < 2);
    pop    = (mq.size() != 0) && bus.m_axis_ready;
    set_o  = 1'b0;
    set_f  = 1'b0;
    pushit = 1'b0;
    w.d    = '0;
    w.l    = 1'b0;
    case (m_mode)
      0: if (pixel_valid_in && pixel_sof_in) begin
           pix_q.delete();
           pix_q.push_back(pixel_data_in);
           m_wcnt = 0;
           m_mode = 1;
         end
      1: if (pixel_valid_in) begin
           if (pixel_sof_in) begin
             set_f = 1'b1;
             pix_q.delete();
             m_mode = 2;
           end else begin
             pix_q.push_back(pixel_data_in);
           end
         end
      default: if (space) begin
           w.d = '0;
           w.l = 1'b1;
           pushit = 1'b1;
           m_mode = 0;
         end
    endcase
    if (m_mode == 1 && pix_q.size() == PPW) begin
      for (int k = 0; k < PPW; k++) w.d = w.d | (128'(pix_q[k]) << (PW * k));
      w.l = (m_wcnt == WORDS - 1);
      pix_q.delete();
      if (space) begin
        pushit = 1'b1;
        if (w.l) m_mode = 0;
        else     m_wcnt++;
      end else begin
        set_o  = 1'b1;
        m_mode = 2;
      end
    end
    if (clr_err_in) begin
      m_ovf  = 1'b0;
      m_ferr = 1'b0;
    end
    if (set_o) m_ovf = 1'b1;
    if (set_f) m_ferr = 1'b1;
    if (pop) void'(mq.pop_front());
    if (pushit) mq.push_back(w);
  endtask

  task automatic check_outputs();
    chk("valid", 128'(bus.m_axis_valid), 128'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("data", bus.m_axis_data, mq[0].d);
      chk("tlast", 128'(bus.m_axis_tlast), 128'(mq[0].l));
    end
    chk("overflow", 128'(overflow_out), 128'(m_ovf));
    chk("frame_err", 128'(frame_err_out), 128'(m_ferr));
    if (bus.m_axis_valid && bus.m_axis_ready) begin
      if (rx_cnt < 16) begin
        rx_d[rx_cnt] = bus.m_axis_data;
        rx_l[rx_cnt] = bus.m_axis_tlast;
      end
      if (bus.m_axis_tlast) rx_tl_cnt++;
      rx_cnt++;
    end
  endtask

  task automatic step();
    @(negedge clk_in);
    check_outputs();
    model_update();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic rx_clear();
    rx_cnt = 0;
    rx_tl_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      rx_d[i] = '0;
      rx_l[i] = 1'b0;
    end
  endtask

  task automatic set_ready(input int rmode);
    case (rmode)
      0:       bus.m_axis_ready = 1'b1;
      1:       bus.m_axis_ready = cyc[0];
      default: bus.m_axis_ready = 1'b0;
    endcase
  endtask

  task automatic drain(input int rmode);
    int n;
    n = 0;
    pixel_valid_in = 1'b0;
    pixel_sof_in   = 1'b0;
    while ((mq.size() != 0 || m_mode != 0) && n < 40) begin
      set_ready(rmode);
      step();
      n++;
    end
    chk("drain_timeout", 128'(mq.size()), 128'(0));
    set_ready(rmode);
    step();
  endtask

  task automatic run_frame(input int pre, input int err_pix, input int rmode, input int npix);
    for (int i = 0; i < pre; i++) begin
      pixel_valid_in = 1'b1;
      pixel_sof_in   = 1'b0;
      pixel_data_in  = PW'(100 + i);
      set_ready(rmode);
      step();
    end
    for (int i = 0; i < npix; i++) begin
      pixel_valid_in = 1'b1;
      pixel_sof_in   = (i == 0) || (i == err_pix);
      pixel_data_in  = PW'(i);
      set_ready(rmode);
      step();
    end
    pixel_valid_in = 1'b0;
    pixel_sof_in   = 1'b0;
  endtask

  task automatic clear_flags();
    clr_err_in = 1'b1;
    step();
    clr_err_in = 1'b0;
    step();
  endtask

  vec_t vecs[4];

  initial begin
    int last;
    int rprob;
    vecs[0] = '{pre: 0, err_pix: -1, rmode: 0, nwords: 4, w_first: W0, w_last: W3, ovf: 1'b0, ferr: 1'b0};
    vecs[1] = '{pre: 5, err_pix: -1, rmode: 0, nwords: 4, w_first: W0, w_last: W3, ovf: 1'b0, ferr: 1'b0};
    vecs[2] = '{pre: 0, err_pix: 12, rmode: 0, nwords: 2, w_first: W0, w_last: '0, ovf: 1'b0, ferr: 1'b1};
    vecs[3] = '{pre: 0, err_pix: -1, rmode: 1, nwords: 4, w_first: W0, w_last: W3, ovf: 1'b0, ferr: 1'b0};

    rst_in           = 1'b0;
    pixel_valid_in   = 1'b0;
    pixel_sof_in     = 1'b0;
    pixel_data_in    = '0;
    clr_err_in       = 1'b0;
    bus.m_axis_ready = 1'b1;
    model_reset();
    rx_clear();
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_valid", 128'(bus.m_axis_valid), 128'(0));
    chk("rst_tlast", 128'(bus.m_axis_tlast), 128'(0));
    chk("rst_data", bus.m_axis_data, 128'(0));
    chk("rst_ovf", 128'(overflow_out), 128'(0));
    chk("rst_ferr", 128'(frame_err_out), 128'(0));
    rst_in = 1'b1;
    step();

    // directed frames from the table
    for (int v = 0; v < 4; v++) begin
      rx_clear();
      run_frame(vecs[v].pre, vecs[v].err_pix, vecs[v].rmode, 32);
      drain(vecs[v].rmode);
      last = (rx_cnt > 0 && rx_cnt <= 16) ? rx_cnt - 1 : 0;
      chk($sformatf("v%0d_nwords", v), 128'(rx_cnt), 128'(vecs[v].nwords));
      chk($sformatf("v%0d_first", v), rx_d[0], vecs[v].w_first);
      chk($sformatf("v%0d_last", v), rx_d[last], vecs[v].w_last);
      chk($sformatf("v%0d_last_tl", v), 128'(rx_l[last]), 128'(1));
      chk($sformatf("v%0d_tl_cnt", v), 128'(rx_tl_cnt), 128'(1));
      chk($sformatf("v%0d_ovf", v), 128'(overflow_out), 128'(vecs[v].ovf));
      chk($sformatf("v%0d_ferr", v), 128'(frame_err_out), 128'(vecs[v].ferr));
      clear_flags();
    end

    // overflow: stall for three words, then release
    rx_clear();
    run_frame(0, -1, 2, 24);
    step();
    chk("ovf_set", 128'(overflow_out), 128'(1));
    drain(0);
    chk("ovf_nwords", 128'(rx_cnt), 128'(3));
    chk("ovf_w0", rx_d[0], W0);
    chk("ovf_w1", rx_d[1], W1);
    chk("ovf_w1_tl", 128'(rx_l[1]), 128'(0));
    chk("ovf_term", rx_d[2], 128'(0));
    chk("ovf_term_tl", 128'(rx_l[2]), 128'(1));
    chk("ovf_sticky", 128'(overflow_out), 128'(1));
    clear_flags();
    rx_clear();
    run_frame(0, -1, 0, 32);
    drain(0);
    chk("post_ovf_nwords", 128'(rx_cnt), 128'(4));
    chk("post_ovf_w3", rx_d[3], W3);

    // reset mid-frame with two words stuck in the buffer
    rx_clear();
    run_frame(0, -1, 2, 20);
    chk("pre_rst_valid", 128'(bus.m_axis_valid), 128'(1));
    #2;
    rst_in = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(bus.m_axis_valid), 128'(0));
    chk("mid_rst_data", bus.m_axis_data, 128'(0));
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rx_clear();
    run_frame(0, -1, 0, 32);
    drain(0);
    chk("post_rst_nwords", 128'(rx_cnt), 128'(4));
    chk("post_rst_w0", rx_d[0], W0);
    chk("post_rst_w3", rx_d[3], W3);

    // random traffic, alternating relaxed and heavy back-pressure
    rprob = 80;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) rprob = (rprob == 80) ? 5 : 80;
      pixel_valid_in   = ($urandom % 4) != 0;
      pixel_sof_in     = pixel_valid_in && (($urandom % 48) == 0);
      pixel_data_in    = PW'($urandom);
      clr_err_in       = ($urandom % 64) == 0;
      bus.m_axis_ready = ($urandom % 100) < rprob;
      step();
    end
    clr_err_in = 1'b0;
    drain(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
